// File: rtl/sram_axi_bridge_mp.sv
// NUM_PORTS SRAM-like request channels arbitrated round-robin onto one AXI3 master.
// Define RAW_HAZARD_CHECK_EN to stall reads that hit the word of the pending write.
module sram_axi_bridge_mp #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned RD_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          port_req,
    input  logic [NUM_PORTS-1:0]          port_wr,
    input  logic [2*NUM_PORTS-1:0]        port_size,
    input  logic [ADDR_W*NUM_PORTS-1:0]   port_addr,
    input  logic [32*NUM_PORTS-1:0]       port_wdata,
    output logic [NUM_PORTS-1:0]          port_addr_ok,
    output logic [NUM_PORTS-1:0]          port_data_ok,
    output logic [31:0]                   port_rdata,
    output logic [3:0]                    arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [2:0]                    arsize,
    output logic                          arvalid,
    input  logic                          arready,
    input  logic [3:0]                    rid,
    input  logic [31:0]                   rdata,
    input  logic                          rvalid,
    output logic                          rready,
    output logic [ADDR_W-1:0]             awaddr,
    output logic [2:0]                    awsize,
    output logic                          awvalid,
    input  logic                          awready,
    output logic [31:0]                   wdata,
    output logic [3:0]                    wstrb,
    output logic                          wvalid,
    input  logic                          wready,
    input  logic                          bvalid,
    output logic                          bready
);

    logic                 ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0]    ar_addr_q, ar_addr_d;
    logic [3:0]           ar_id_q, ar_id_d;
    logic [2:0]           ar_size_q, ar_size_d;
    logic                 aw_valid_q, aw_valid_d;
    logic                 w_valid_q, w_valid_d;
    logic [ADDR_W-1:0]    aw_addr_q, aw_addr_d;
    logic [2:0]           aw_size_q, aw_size_d;
    logic [31:0]          w_data_q, w_data_d;
    logic [3:0]           w_strb_q, w_strb_d;
    logic                 wr_busy_q, wr_busy_d;
    logic [3:0]           wr_owner_q, wr_owner_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [3:0]           rd_cnt_q [NUM_PORTS];
    logic [3:0]           rd_cnt_d [NUM_PORTS];

    logic                 ar_free;
    logic                 b_hs;
    logic                 bready_c;
    logic                 found;
    logic                 taken;
    logic [2:0]           sel;
    logic [NUM_PORTS-1:0] raw_hit;
    logic [NUM_PORTS-1:0] acc;
    logic [NUM_PORTS-1:0] hi_acc;
    logic [NUM_PORTS-1:0] vec;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] data_ok;
    logic                 sel_wr;
    logic [1:0]           sel_size;
    logic [ADDR_W-1:0]    sel_addr;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_strb;
    logic                 inc;
    logic                 dec;

    always_comb begin
        ar_free  = !ar_valid_q || arready;
        bready_c = !(rvalid && (rid == wr_owner_q));
        b_hs     = bvalid && bready_c;

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            raw_hit[i] = 1'b0;
`ifdef RAW_HAZARD_CHECK_EN
            raw_hit[i] = wr_busy_q &&
                         (port_addr[i*ADDR_W+2 +: ADDR_W-2] == aw_addr_q[ADDR_W-1:2]);
`endif
            if (port_wr[i])
                acc[i] = port_req[i] && !wr_busy_q;
            else
                acc[i] = port_req[i] && ar_free && !raw_hit[i] &&
                         (rd_cnt_q[i] < 4'(RD_OUTSTANDING));
            hi_acc[i] = acc[i] && (i[2:0] >= rr_ptr_q);
        end

        // Ports at or after the pointer win; otherwise wrap around to the lowest index.
        found = |acc;
        vec   = (|hi_acc) ? hi_acc : acc;
        taken = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (vec[i] && !taken) begin
                sel   = i[2:0];
                taken = 1'b1;
            end
        end

        sel_wr    = 1'b0;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            grant[i] = found && (sel == i[2:0]);
            if (grant[i]) begin
                sel_wr    = port_wr[i];
                sel_size  = port_size[i*2 +: 2];
                sel_addr  = port_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = port_wdata[i*32 +: 32];
            end
        end

        case (sel_size)
            2'd0:    sel_strb = 4'b0001 << sel_addr[1:0];
            2'd1:    sel_strb = 4'b0011 << {sel_addr[1], 1'b0};
            default: sel_strb = 4'b1111;
        endcase

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            data_ok[i] = (rvalid && (rid == i[3:0])) || (b_hs && (wr_owner_q == i[3:0]));
            inc = grant[i] && !port_wr[i];
            dec = rvalid && (rid == i[3:0]) && (rd_cnt_q[i] != '0);
            rd_cnt_d[i] = rd_cnt_q[i];
            if (inc && !dec)
                rd_cnt_d[i] = rd_cnt_q[i] + 4'd1;
            else if (dec && !inc)
                rd_cnt_d[i] = rd_cnt_q[i] - 4'd1;
        end

        ar_valid_d = ar_valid_q && !arready;
        ar_addr_d  = ar_addr_q;
        ar_id_d    = ar_id_q;
        ar_size_d  = ar_size_q;
        if (found && !sel_wr) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = sel_addr;
            ar_id_d    = {1'b0, sel};
            ar_size_d  = {1'b0, sel_size};
        end

        aw_valid_d = aw_valid_q && !awready;
        w_valid_d  = w_valid_q && !wready;
        aw_addr_d  = aw_addr_q;
        aw_size_d  = aw_size_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        wr_busy_d  = wr_busy_q && !b_hs;
        wr_owner_d = wr_owner_q;
        if (found && sel_wr) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = sel_addr;
            aw_size_d  = {1'b0, sel_size};
            w_data_d   = sel_wdata;
            w_strb_d   = sel_strb;
            wr_busy_d  = 1'b1;
            wr_owner_d = {1'b0, sel};
        end

        rr_ptr_d = rr_ptr_q;
        if (found)
            rr_ptr_d = (sel == 3'(NUM_PORTS-1)) ? 3'd0 : sel + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_size_q  <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_size_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wr_busy_q  <= 1'b0;
            wr_owner_q <= '0;
            rr_ptr_q   <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                rd_cnt_q[i] <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_id_q    <= ar_id_d;
            ar_size_q  <= ar_size_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_addr_q  <= aw_addr_d;
            aw_size_q  <= aw_size_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            wr_busy_q  <= wr_busy_d;
            wr_owner_q <= wr_owner_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                rd_cnt_q[i] <= rd_cnt_d[i];
        end
    end

    assign port_addr_ok = grant;
    assign port_data_ok = data_ok;
    assign port_rdata   = rdata;
    assign arid         = ar_id_q;
    assign araddr       = ar_addr_q;
    assign arsize       = ar_size_q;
    assign arvalid      = ar_valid_q;
    assign rready       = 1'b1;
    assign awaddr       = aw_addr_q;
    assign awsize       = aw_size_q;
    assign awvalid      = aw_valid_q;
    assign wdata        = w_data_q;
    assign wstrb        = w_strb_q;
    assign wvalid       = w_valid_q;
    assign bready       = bready_c;

endmodule

// File: tb/tb_sram_axi_bridge_mp.sv
// Scoreboard bench for sram_axi_bridge_mp: directed stimulus pushes expected
// grants and AXI/data_ok events; a negedge monitor pops and compares them.
module tb_sram_axi_bridge_mp;

    localparam int NP = 2;
    localparam int AW = 32;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     port_req;
    logic [NP-1:0]     port_wr;
    logic [2*NP-1:0]   port_size;
    logic [AW*NP-1:0]  port_addr;
    logic [32*NP-1:0]  port_wdata;
    logic [NP-1:0]     port_addr_ok;
    logic [NP-1:0]     port_data_ok;
    logic [31:0]       port_rdata;
    logic [3:0]        arid;
    logic [AW-1:0]     araddr;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              rready;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;

    sram_axi_bridge_mp #(
        .NUM_PORTS      (NP),
        .ADDR_W         (AW),
        .RD_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .port_req     (port_req),
        .port_wr      (port_wr),
        .port_size    (port_size),
        .port_addr    (port_addr),
        .port_wdata   (port_wdata),
        .port_addr_ok (port_addr_ok),
        .port_data_ok (port_data_ok),
        .port_rdata   (port_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    typedef struct packed {
        logic [3:0]    id;
        logic [2:0]    size;
        logic [AW-1:0] addr;
    } ar_t;

    typedef struct packed {
        logic [2:0]    size;
        logic [AW-1:0] addr;
    } aw_t;

    typedef struct packed {
        logic [3:0]  strb;
        logic [31:0] data;
    } w_t;

    typedef struct packed {
        logic [NP-1:0] mask;
        logic          rd;
        logic [31:0]   data;
    } dok_t;

    int   q_grant[$];
    ar_t  q_ar[$];
    aw_t  q_aw[$];
    w_t   q_w[$];
    dok_t q_dok[$];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected no event (t=%0t)", name, act, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [1:0] s);
        port_req[p]          = 1'b1;
        port_wr[p]           = 1'b0;
        port_size[p*2 +: 2]  = s;
        port_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        port_req[p]           = 1'b1;
        port_wr[p]            = 1'b1;
        port_size[p*2 +: 2]   = s;
        port_addr[p*AW +: AW] = a;
        port_wdata[p*32 +: 32] = d;
    endtask

    task automatic clr();
        port_req = '0;
    endtask

    task automatic push_ar(input logic [3:0] id, input logic [2:0] s, input logic [31:0] a);
        ar_t e;
        e.id = id; e.size = s; e.addr = a;
        q_ar.push_back(e);
    endtask

    task automatic push_wr(input logic [2:0] s, input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
        aw_t ea;
        w_t  ew;
        ea.size = s; ea.addr = a;
        ew.strb = st; ew.data = d;
        q_aw.push_back(ea);
        q_w.push_back(ew);
    endtask

    task automatic push_dok(input logic [NP-1:0] m, input logic r, input logic [31:0] d);
        dok_t e;
        e.mask = m; e.rd = r; e.data = d;
        q_dok.push_back(e);
    endtask

    // Monitor: every visible output event must match the next expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (port_addr_ok != '0) begin
                if (q_grant.size() == 0) unexpected("addr_ok_extra", 64'(port_addr_ok));
                else begin
                    logic [NP-1:0] one;
                    int g;
                    g = q_grant.pop_front();
                    one = '0;
                    one[g] = 1'b1;
                    check("addr_ok", 64'(port_addr_ok), 64'(one));
                end
            end
            if (arvalid && arready) begin
                if (q_ar.size() == 0) unexpected("ar_extra", 64'(araddr));
                else begin
                    ar_t e;
                    e = q_ar.pop_front();
                    check("araddr", 64'(araddr), 64'(e.addr));
                    check("arid", 64'(arid), 64'(e.id));
                    check("arsize", 64'(arsize), 64'(e.size));
                end
            end
            if (awvalid && awready) begin
                if (q_aw.size() == 0) unexpected("aw_extra", 64'(awaddr));
                else begin
                    aw_t e;
                    e = q_aw.pop_front();
                    check("awaddr", 64'(awaddr), 64'(e.addr));
                    check("awsize", 64'(awsize), 64'(e.size));
                end
            end
            if (wvalid && wready) begin
                if (q_w.size() == 0) unexpected("w_extra", 64'(wdata));
                else begin
                    w_t e;
                    e = q_w.pop_front();
                    check("wdata", 64'(wdata), 64'(e.data));
                    check("wstrb", 64'(wstrb), 64'(e.strb));
                end
            end
            if (port_data_ok != '0) begin
                if (q_dok.size() == 0) unexpected("data_ok_extra", 64'(port_data_ok));
                else begin
                    dok_t e;
                    e = q_dok.pop_front();
                    check("data_ok", 64'(port_data_ok), 64'(e.mask));
                    if (e.rd) check("port_rdata", 64'(port_rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        port_req = '0; port_wr = '0; port_size = '0; port_addr = '0; port_wdata = '0;
        arready = 1'b0; rid = '0; rdata = '0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_addr_ok", 64'(port_addr_ok), 64'd0);
        check("rst_data_ok", 64'(port_data_ok), 64'd0);
        check("rst_rready", 64'(rready), 64'd1);
        check("rst_bready", 64'(bready), 64'd1);
        tick(); rst = 1'b0;

        // Single read, data back three cycles after accept.
        tick(); arready = 1'b1; rd(0, 32'h1c00_0000, 2'd2);
        q_grant.push_back(0); push_ar(4'd0, 3'b010, 32'h1c00_0000);
        tick(); clr();
        @(negedge clk); check("t1_arvalid_c1", 64'(arvalid), 64'd1);
        tick();
        @(negedge clk); check("t1_arvalid_c2", 64'(arvalid), 64'd0);
        tick(); rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
        push_dok(2'b01, 1'b1, 32'hDEAD_BEEF);
        tick(); rvalid = 1'b0;

        tick(); rst = 1'b1;
        tick(); rst = 1'b0;

        // Both ports read every cycle: 0,1,0,1 then stall at the outstanding limit.
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 0) begin
                rd(0, 32'h0000_1000, 2'd2);
                rd(1, 32'h0000_2000, 2'd2);
            end
            if (k < 4) begin
                q_grant.push_back(k % 2);
                push_ar(4'(k % 2), 3'b010, (k % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000);
            end
        end
        tick(); clr();

        // Full read port is skipped; write granted; reset kills it; counters restart.
        tick(); arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rd(0, 32'h0000_0500, 2'd2); wr(1, 32'h0000_0400, 2'd2, 32'h9999_9999);
        q_grant.push_back(1);
        tick(); clr();
        @(negedge clk);
        check("rs_awvalid_pre", 64'(awvalid), 64'd1);
        check("rs_wvalid_pre", 64'(wvalid), 64'd1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; arready = 1'b1;
        rd(0, 32'h0000_0600, 2'd2); rd(1, 32'h0000_0700, 2'd2);
        q_grant.push_back(0); push_ar(4'd0, 3'b010, 32'h0000_0600);
        @(negedge clk);
        check("rs_awvalid_post", 64'(awvalid), 64'd0);
        check("rs_wvalid_post", 64'(wvalid), 64'd0);
        check("rs_arvalid_post", 64'(arvalid), 64'd0);
        tick();
        q_grant.push_back(1); push_ar(4'd1, 3'b010, 32'h0000_0700);
        tick(); clr();
        tick(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h0A0A_0A0A;
        push_dok(2'b01, 1'b1, 32'h0A0A_0A0A);
        tick(); rid = 4'd1; rdata = 32'h0B0B_0B0B;
        push_dok(2'b10, 1'b1, 32'h0B0B_0B0B);
        tick(); rid = 4'd5; rdata = 32'hFFFF_FFFF;
        @(negedge clk); check("rid_out_of_range", 64'(port_data_ok), 64'd0);
        tick(); rvalid = 1'b0; rid = 4'd0;

        // Byte write with delayed AW; a second write waits for B.
        tick(); awready = 1'b0; wready = 1'b1;
        wr(1, 32'h0000_0203, 2'd0, 32'hAB00_0000);
        q_grant.push_back(1); push_wr(3'b000, 32'h0000_0203, 4'b1000, 32'hAB00_0000);
        tick(); clr(); wr(0, 32'h0000_0800, 2'd2, 32'h1111_1111);
        @(negedge clk);
        check("t3_awvalid_c1", 64'(awvalid), 64'd1);
        check("t3_wvalid_c1", 64'(wvalid), 64'd1);
        tick();
        @(negedge clk);
        check("t3_wvalid_c2", 64'(wvalid), 64'd0);
        check("t3_awvalid_c2", 64'(awvalid), 64'd1);
        tick(); awready = 1'b1;
        @(negedge clk); check("t3_awvalid_c3", 64'(awvalid), 64'd1);
        tick(); awready = 1'b0;
        @(negedge clk); check("t3_awvalid_c4", 64'(awvalid), 64'd0);
        tick(); bvalid = 1'b1;
        push_dok(2'b10, 1'b0, 32'h0);
        @(negedge clk); check("t3_bready", 64'(bready), 64'd1);
        tick(); bvalid = 1'b0; clr();

        // Read data and B for the same port collide: read first, B next cycle.
        tick(); arready = 1'b1; awready = 1'b1; wready = 1'b1;
        rd(1, 32'h0000_3000, 2'd2);
        q_grant.push_back(1); push_ar(4'd1, 3'b010, 32'h0000_3000);
        tick(); clr(); wr(1, 32'h0000_3004, 2'd2, 32'h1234_5678);
        q_grant.push_back(1); push_wr(3'b010, 32'h0000_3004, 4'b1111, 32'h1234_5678);
        tick(); clr();
        tick(); rvalid = 1'b1; rid = 4'd1; rdata = 32'hCAFE_F00D; bvalid = 1'b1;
        push_dok(2'b10, 1'b1, 32'hCAFE_F00D);
        @(negedge clk); check("t4_bready_blocked", 64'(bready), 64'd0);
        tick(); rvalid = 1'b0; rid = 4'd0;
        push_dok(2'b10, 1'b0, 32'h0);
        @(negedge clk); check("t4_bready_free", 64'(bready), 64'd1);
        tick(); bvalid = 1'b0;

        // Half write pending, reads to another word and to the same word.
        tick(); wr(1, 32'h0000_0102, 2'd1, 32'hBEEF_0000);
        q_grant.push_back(1); push_wr(3'b001, 32'h0000_0102, 4'b1100, 32'hBEEF_0000);
        tick(); clr(); rd(0, 32'h0000_0104, 2'd2);
        q_grant.push_back(0); push_ar(4'd0, 3'b010, 32'h0000_0104);
        tick(); rd(0, 32'h0000_0100, 2'd2);
`ifndef RAW_HAZARD_CHECK_EN
        q_grant.push_back(0); push_ar(4'd0, 3'b010, 32'h0000_0100);
`endif
        tick(); bvalid = 1'b1;
        push_dok(2'b10, 1'b0, 32'h0);
`ifndef RAW_HAZARD_CHECK_EN
        clr();
`endif
        tick(); bvalid = 1'b0;
`ifdef RAW_HAZARD_CHECK_EN
        q_grant.push_back(0); push_ar(4'd0, 3'b010, 32'h0000_0100);
`endif
        tick(); clr();
        tick(); rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_2222;
        push_dok(2'b01, 1'b1, 32'h1111_2222);
        tick(); rdata = 32'h3333_4444;
        push_dok(2'b01, 1'b1, 32'h3333_4444);
        tick(); rvalid = 1'b0;
        tick(); tick();

        check("grant_q_empty", 64'(q_grant.size()), 64'd0);
        check("ar_q_empty", 64'(q_ar.size()), 64'd0);
        check("aw_q_empty", 64'(q_aw.size()), 64'd0);
        check("w_q_empty", 64'(q_w.size()), 64'd0);
        check("dok_q_empty", 64'(q_dok.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
